// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared constants for the 8-key piano front end and tone mixer
package piano_pkg;

    localparam int NUM_KEYS = 8;
    localparam int CLK_HZ   = 12000000;

    localparam logic KEY_RELEASED = 1'b1;

    // Half-period divisors (CLK_HZ / (2 * f_note)) for C4..C5, one per key.
    localparam int unsigned NOTE_HALF_PERIOD [NUM_KEYS] = '{
        22933,  // C4 261.63 Hz
        20432,  // D4 293.66 Hz
        18202,  // E4 329.63 Hz
        17181,  // F4 349.23 Hz
        15306,  // G4 392.00 Hz
        13636,  // A4 440.00 Hz
        12149,  // B4 493.88 Hz
        11467   // C5 523.25 Hz
    };

    function automatic int unsigned note_half_period(input int key_idx);
        return NOTE_HALF_PERIOD[key_idx];
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// rtl/key_debounce_cell.sv - per-key synchroniser, tick-sampled integrator and pulse logic
// Optional sustain behaviour selected by KEY_LATCH_MODE_EN.
module key_debounce_cell
    import piano_pkg::*;
#(
    parameter int STABLE_SAMPLES = 8
) (
    input  logic CLK_IN,
    input  logic RST_N,
    input  logic tick,
    input  logic sw_raw,
    output logic sw_clean,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int             CW       = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(STABLE_SAMPLES - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level_q;
    logic [CW-1:0] cnt_q;
    logic          accept;

    // Accepting edge: the last of STABLE_SAMPLES consecutive differing ticks.
    assign accept = tick && (sync_q2 != level_q) && (cnt_q == CNT_LAST);

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            sync_q1       <= KEY_RELEASED;
            sync_q2       <= KEY_RELEASED;
            level_q       <= KEY_RELEASED;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync_q1       <= sw_raw;
            sync_q2       <= sync_q1;
            press_pulse   <= accept && !sync_q2;
            release_pulse <= accept && sync_q2;
            if (tick) begin
                if (sync_q2 == level_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    level_q <= sync_q2;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef KEY_LATCH_MODE_EN
    logic latch_q;

    // Sustain: each debounced press flips the output; releases leave it alone.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            latch_q <= KEY_RELEASED;
        end else if (accept && !sync_q2) begin
            latch_q <= ~latch_q;
        end
    end

    assign sw_clean = latch_q;
`else
    assign sw_clean = level_q;
`endif

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - debounces NUM_KEYS active-low key switches for the tone mixer
// Optional sustain mode via KEY_LATCH_MODE_EN (handled in key_debounce_cell).
module key_debounce
    import piano_pkg::*;
#(
    parameter int NUM_KEYS       = piano_pkg::NUM_KEYS,
    parameter int CLK_HZ         = piano_pkg::CLK_HZ,
    parameter int SAMPLE_HZ      = 1000,
    parameter int STABLE_SAMPLES = 8
) (
    input  logic                CLK_IN,
    input  logic                RST_N,
    input  logic [NUM_KEYS-1:0] SW_RAW,
    output logic [NUM_KEYS-1:0] SW_CLEAN,
    output logic [NUM_KEYS-1:0] PRESS_PULSE,
    output logic [NUM_KEYS-1:0] RELEASE_PULSE,
    output logic                ANY_KEY
);

    localparam int            DIV      = CLK_HZ / SAMPLE_HZ;
    localparam int            DW       = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [DW-1:0] div_q;
    logic          tick;

    assign tick = (div_q == DIV_LAST);

    // Free-running sample divider shared by every key.
    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce_cell #(
            .STABLE_SAMPLES(STABLE_SAMPLES)
        ) u_cell (
            .CLK_IN       (CLK_IN),
            .RST_N        (RST_N),
            .tick         (tick),
            .sw_raw       (SW_RAW[k]),
            .sw_clean     (SW_CLEAN[k]),
            .press_pulse  (PRESS_PULSE[k]),
            .release_pulse(RELEASE_PULSE[k])
        );
    end

    always_ff @(posedge CLK_IN or negedge RST_N) begin
        if (!RST_N) begin
            ANY_KEY <= 1'b0;
        end else begin
            ANY_KEY <= ~&SW_CLEAN;
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce (DIV=12, STABLE_SAMPLES=4)
module tb_key_debounce;

    logic       CLK_IN = 1'b0;
    logic       RST_N  = 1'b0;
    logic [7:0] SW_RAW = 8'hFF;
    logic [7:0] SW_CLEAN;
    logic [7:0] PRESS_PULSE;
    logic [7:0] RELEASE_PULSE;
    logic       ANY_KEY;

    key_debounce #(
        .NUM_KEYS      (8),
        .CLK_HZ        (1200),
        .SAMPLE_HZ     (100),
        .STABLE_SAMPLES(4)
    ) dut (
        .CLK_IN       (CLK_IN),
        .RST_N        (RST_N),
        .SW_RAW       (SW_RAW),
        .SW_CLEAN     (SW_CLEAN),
        .PRESS_PULSE  (PRESS_PULSE),
        .RELEASE_PULSE(RELEASE_PULSE),
        .ANY_KEY      (ANY_KEY)
    );

    always #5 CLK_IN = ~CLK_IN;

    int cyc = 0;
    always @(posedge CLK_IN) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] press;
        logic [7:0] rel;
        logic [7:0] clean;
        int         t0;
        int         lo;
        int         hi;
    } exp_t;

    exp_t       q[$];
    logic [7:0] lvl = 8'hFF;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int v, input int lo, input int hi);
        total++;
        if (v < lo || v > hi) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, v, lo, hi);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] cur, input logic [7:0] pm,
                                         input logic [7:0] rm);
`ifdef KEY_LATCH_MODE_EN
        return cur ^ pm;
`else
        return (cur & ~pm) | rm;
`endif
    endfunction

    task automatic expect_evt(input logic [7:0] pm, input logic [7:0] rm, input int lo, input int hi);
        exp_t e;
        lvl     = model(lvl, pm, rm);
        e.press = pm;
        e.rel   = rm;
        e.clean = lvl;
        e.t0    = cyc;
        e.lo    = lo;
        e.hi    = hi;
        q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge CLK_IN);
            n++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s timeout pending=%0d expected=0", name, q.size());
            q.delete();
        end
        repeat (3) @(negedge CLK_IN);
    endtask

    // Monitor: consumes one scoreboard entry per cycle with any pulse present.
    logic [7:0] mon_clean = 8'hFF;
    logic       any_pend  = 1'b0;
    exp_t       mon_e;

    always @(negedge CLK_IN) begin
        if (!RST_N) begin
            mon_clean = 8'hFF;
            any_pend  = 1'b0;
        end else begin
            if (any_pend) begin
                check8("any_key_follow", {7'b0, ANY_KEY}, {7'b0, ~&mon_clean});
                any_pend = 1'b0;
            end
            if ((PRESS_PULSE | RELEASE_PULSE) != 8'h00) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pulse press=%h release=%h expected none at cyc=%0d",
                             PRESS_PULSE, RELEASE_PULSE, cyc);
                end else begin
                    mon_e = q.pop_front();
                    check8("press_pulse", PRESS_PULSE, mon_e.press);
                    check8("release_pulse", RELEASE_PULSE, mon_e.rel);
                    check8("sw_clean_at_pulse", SW_CLEAN, mon_e.clean);
                    check8("any_key_lag", {7'b0, ANY_KEY}, {7'b0, ~&mon_clean});
                    check_rng("latency", cyc - mon_e.t0, mon_e.lo, mon_e.hi);
                    mon_clean = mon_e.clean;
                    any_pend  = 1'b1;
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLK_IN);
        check8("reset_sw_clean", SW_CLEAN, 8'hFF);
        check8("reset_press", PRESS_PULSE, 8'h00);
        check8("reset_release", RELEASE_PULSE, 8'h00);
        check8("reset_any", {7'b0, ANY_KEY}, 8'h00);
        @(negedge CLK_IN);
        RST_N = 1'b1;
        repeat (20) @(negedge CLK_IN);

        // Single key press / release
        SW_RAW = 8'hFE;
        expect_evt(8'h01, 8'h00, 38, 50);
        drain("press_key0");
        SW_RAW = 8'hFF;
        expect_evt(8'h00, 8'h01, 38, 50);
        drain("release_key0");

        // Bouncing key 3: 15-cycle levels never give 4 differing ticks
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK_IN);
            if (i % 15 == 0) begin
                SW_RAW[3] = ~SW_RAW[3];
                if (i == 90) expect_evt(8'h08, 8'h00, 37, 60);
            end
        end
        drain("bounce_key3");
        SW_RAW = 8'hFF;
        expect_evt(8'h00, 8'h08, 38, 50);
        drain("bounce_release");

        // Simultaneous keys 1 and 6
        SW_RAW = 8'hBD;
        expect_evt(8'h42, 8'h00, 38, 50);
        drain("multi_press");
        check8("multi_clean", SW_CLEAN, lvl);
        SW_RAW = 8'hFF;
        expect_evt(8'h00, 8'h42, 38, 50);
        drain("multi_release");

        // Short glitch on key 5 is rejected
        SW_RAW = 8'hDF;
        repeat (30) @(negedge CLK_IN);
        SW_RAW = 8'hFF;
        repeat (80) @(negedge CLK_IN);
        check8("glitch_clean", SW_CLEAN, lvl);

        // Key 2 pressed and released twice
        for (int r = 0; r < 2; r++) begin
            SW_RAW = 8'hFB;
            expect_evt(8'h04, 8'h00, 38, 50);
            drain("key2_press");
            check8("key2_clean_after_press", {7'b0, SW_CLEAN[2]}, {7'b0, lvl[2]});
            SW_RAW = 8'hFF;
            expect_evt(8'h00, 8'h04, 38, 50);
            drain("key2_release");
            check8("key2_clean_after_release", {7'b0, SW_CLEAN[2]}, {7'b0, lvl[2]});
        end

        // Asynchronous reset with all keys held down
        SW_RAW = 8'h00;
        expect_evt(8'hFF, 8'h00, 38, 50);
        drain("all_press");
        @(negedge CLK_IN);
        #2;
        RST_N = 1'b0;
        lvl   = 8'hFF;
        #1;
        check8("async_reset_clean", SW_CLEAN, 8'hFF);
        check8("async_reset_press", PRESS_PULSE, 8'h00);
        check8("async_reset_release", RELEASE_PULSE, 8'h00);
        check8("async_reset_any", {7'b0, ANY_KEY}, 8'h00);
        repeat (3) @(negedge CLK_IN);
        RST_N = 1'b1;
        expect_evt(8'hFF, 8'h00, 48, 48);
        drain("post_reset_press");
        SW_RAW = 8'hFF;
        expect_evt(8'h00, 8'hFF, 38, 50);
        drain("post_reset_release");

        repeat (10) @(negedge CLK_IN);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
